// File: rtl/sm_fixed_mult_seq_if.sv
// Operand/result handshake bundle for the sequential sign-magnitude multiplier.
// master drives operands and accepts results; slave is the multiplier.
interface sm_fixed_mult_seq_if #(
    parameter int unsigned WIDTH = 31
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   inputA;
    logic [WIDTH:0]   inputB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             sat;

    modport master (
        output in_valid, inputA, inputB, out_ready,
        input  in_ready, out_valid, result, sat
    );

    modport slave (
        input  in_valid, inputA, inputB, out_ready,
        output in_ready, out_valid, result, sat
    );
endinterface

// File: rtl/sm_fixed_mult_seq.sv
// Radix-2 shift-add sign-magnitude fixed-point multiplier, WIDTH cycles per product,
// with selectable truncate/round, magnitude saturation and canonical +0.
module sm_fixed_mult_seq #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned ROUND = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    sm_fixed_mult_seq_if.slave   bus
);
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [AW:0] RND = (ROUND != 0 && FRAC > 0)
                                  ? ((AW + 1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0))
                                  : '0;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_NORM, S_DONE} state_e;

    state_e           state_q,     state_d;
    logic             sign_q,      sign_d;
    logic [WIDTH-1:0] ma_q,        ma_d;
    logic [WIDTH-1:0] mb_q,        mb_d;
    logic [AW-1:0]    acc_q,       acc_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   result_q,    result_d;
    logic             sat_q,       sat_d;

    logic [WIDTH:0]   part_sum;
    logic [AW:0]      rnd_sum;
    logic [AW:0]      scaled;
    logic             ovf;
    logic [WIDTH-1:0] mag;

    // Datapath: right-shifting accumulator leaves the full product in acc after WIDTH steps
    always_comb begin
        part_sum = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, ma_q & {WIDTH{mb_q[0]}}};
        rnd_sum  = {1'b0, acc_q} + RND;
        scaled   = rnd_sum >> FRAC;
        ovf      = |scaled[AW:WIDTH];
        mag      = ovf ? '1 : scaled[WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_d       = sat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.inputA[WIDTH] ^ bus.inputB[WIDTH];
                    ma_d    = bus.inputA[WIDTH-1:0];
                    mb_d    = bus.inputB[WIDTH-1:0];
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d = {part_sum, acc_q[WIDTH-1:1]};
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // a zero magnitude always leaves with a positive sign
                result_d    = {sign_q & (mag != '0), mag};
                sat_d       = ovf;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_sm_fixed_mult_seq.sv
// Scoreboard bench: a truncating and a rounding multiplier run in lock-step on shared stimulus.
module tb_sm_fixed_mult_seq;
    localparam int unsigned W    = 31;
    localparam int unsigned FRAC = 16;
    localparam int          N_RANDOM = 1000;

    typedef struct {
        logic [W:0] res_t;
        logic       sat_t;
        logic [W:0] res_r;
        logic       sat_r;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [W:0] inputA;
    logic [W:0] inputB;
    logic       out_ready;
    int         rdy_mode;
    int         n_checks;
    int         n_fail;
    exp_t       sb[$];

    sm_fixed_mult_seq_if #(.WIDTH(W)) bus_t ();
    sm_fixed_mult_seq_if #(.WIDTH(W)) bus_r ();

    assign bus_t.in_valid  = in_valid;
    assign bus_t.inputA    = inputA;
    assign bus_t.inputB    = inputB;
    assign bus_t.out_ready = out_ready;
    assign bus_r.in_valid  = in_valid;
    assign bus_r.inputA    = inputA;
    assign bus_r.inputB    = inputB;
    assign bus_r.out_ready = out_ready;

    sm_fixed_mult_seq #(.WIDTH(W), .FRAC(FRAC), .ROUND(0)) dut_t (.clk(clk), .rst(rst), .bus(bus_t));
    sm_fixed_mult_seq #(.WIDTH(W), .FRAC(FRAC), .ROUND(1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W:0] a, input logic [W:0] b, input bit rnd);
        longint unsigned p;
        longint unsigned m;
        logic [W-1:0]    mag;
        logic            s;
        p = 64'(a[W-1:0]) * 64'(b[W-1:0]);
        if (rnd) p = p + (64'd1 << (FRAC - 1));
        m = p >> FRAC;
        s = (m > 64'h7FFF_FFFF);
        mag = s ? '1 : m[W-1:0];
        return {s, (mag != '0) & (a[W] ^ b[W]), mag};
    endfunction

    function automatic exp_t model_pair(input logic [W:0] a, input logic [W:0] b);
        exp_t        e;
        logic [W+1:0] t;
        logic [W+1:0] r;
        t = model(a, b, 1'b0);
        r = model(a, b, 1'b1);
        e.sat_t = t[W+1];
        e.res_t = t[W:0];
        e.sat_r = r[W+1];
        e.res_r = r[W:0];
        return e;
    endfunction

    function automatic logic [W:0] rand_op();
        logic [W:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v = {v[W], {W{1'b0}}};
            1: v = {v[W], {W{1'b1}}};
            2: v = {v[W], W'($urandom_range(0, 255))};
            3: v = {v[W], W'($urandom_range(0, 32'h3_FFFF))};
            default: ;
        endcase
        return v;
    endfunction

    // Random or forced consumer readiness, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_t.out_valid && out_ready) begin
            check_eq("valid_lockstep", 64'(bus_r.out_valid), 64'd1);
            if (sb.size() == 0) begin
                check_eq("unexpected_output", 64'(bus_t.result), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("result_trunc", 64'(bus_t.result), 64'(e.res_t));
                check_eq("sat_trunc",    64'(bus_t.sat),    64'(e.sat_t));
                check_eq("result_round", 64'(bus_r.result), 64'(e.res_r));
                check_eq("sat_round",    64'(bus_r.sat),    64'(e.sat_r));
            end
        end
    end

    task automatic send(input logic [W:0] a, input logic [W:0] b, input exp_t e, input bit push);
        int n;
        @(negedge clk);
        inputA   = a;
        inputB   = b;
        in_valid = 1'b1;
        n = 0;
        while (!bus_t.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check_eq("accept_timeout", 64'(n), 64'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inputA   = $urandom;
        inputB   = $urandom;
        if (push) sb.push_back(e);
    endtask

    task automatic send_exp(input logic [W:0] a, input logic [W:0] b,
                            input logic [W:0] rt, input logic st,
                            input logic [W:0] rr, input logic sr);
        exp_t e;
        e.res_t = rt;
        e.sat_t = st;
        e.res_r = rr;
        e.sat_r = sr;
        send(a, b, e, 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_reset(input string tag);
        check_eq({tag, "_out_valid"}, 64'(bus_t.out_valid), 64'd0);
        check_eq({tag, "_result"},    64'(bus_t.result),    64'd0);
        check_eq({tag, "_sat"},       64'(bus_t.sat),       64'd0);
        check_eq({tag, "_in_ready"},  64'(bus_t.in_ready),  64'd1);
        check_eq({tag, "_result_r"},  64'(bus_r.result),    64'd0);
        check_eq({tag, "_in_ready_r"}, 64'(bus_r.in_ready), 64'd1);
    endtask

    initial begin
        int k;
        logic [W:0] a;
        logic [W:0] b;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        inputA    = '0;
        inputB    = '0;
        out_ready = 1'b1;
        rdy_mode  = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_reset("reset");

        // 1.5 x -2.0 with exact latency
        send_exp(32'h0001_8000, 32'h8002_0000, 32'h8003_0000, 1'b0, 32'h8003_0000, 1'b0);
        for (k = 1; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (bus_t.out_valid) break;
        end
        check_eq("latency", 64'(k), 64'd32);
        wait_drain();

        send_exp(32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1);
        send_exp(32'h7FFF_0000, 32'h8002_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        send_exp(32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
        send_exp(32'h0000_0100, 32'h0000_0080, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0);
        send_exp(32'h8000_0100, 32'h0000_0080, 32'h0000_0000, 1'b0, 32'h8000_0001, 1'b0);
        send_exp(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
        wait_drain();

        // Backpressure: result held, operands ignored while the consumer stalls
        rdy_mode  = 2;
        out_ready = 1'b0;
        send_exp(32'h0001_8000, 32'h8002_0000, 32'h8003_0000, 1'b0, 32'h8003_0000, 1'b0);
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (bus_t.out_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_out_valid", 64'(bus_t.out_valid), 64'd1);
            check_eq("bp_result",    64'(bus_t.result),    64'h8003_0000);
            check_eq("bp_in_ready",  64'(bus_t.in_ready),  64'd0);
            if (i == 0) begin
                in_valid = 1'b1;
                inputA   = 32'h0004_0000;
                inputB   = 32'h0004_0000;
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rdy_mode  = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_in_ready",  64'(bus_t.in_ready),  64'd1);
        check_eq("bp_release_out_valid", 64'(bus_t.out_valid), 64'd0);
        check_eq("bp_result_kept",       64'(bus_t.result),    64'h8003_0000);
        wait_drain();

        // Reset in the middle of BUSY drops the operation
        send_exp(32'h0003_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle_reset("abort");
        send_exp(32'h0001_8000, 32'h8002_0000, 32'h8003_0000, 1'b0, 32'h8003_0000, 1'b0);
        wait_drain();

        // Random operands with random consumer stalls
        rdy_mode = 1;
        for (int i = 0; i < N_RANDOM; i++) begin
            a = rand_op();
            b = rand_op();
            send(a, b, model_pair(a, b), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();
        rdy_mode = 0;
        repeat (40) @(negedge clk);
        check_eq("final_queue", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
